tx_header_serializer: RTL and testbench

//   Downstream of the packet builder. Accepts one assembled 54-byte Ethernet+IPv4+TCP header
//   (14+20+20 bytes) as a flat vector and inserts the IPv4 header checksum.

---
 rtl/tx_header_serializer.sv | 164 ++++++++++++++++
 tb/tb_tx_header_serializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_header_serializer.sv
// tx_header_serializer: latches one 54-byte Ethernet/IPv4/TCP header, optionally inserts the
// IPv4 header checksum (bytes 24-25) and streams it as 14 big-endian 32-bit words.
module tx_header_serializer #(
  parameter logic CSUM_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         hdr_valid,
  output logic         hdr_ready,
  input  logic [431:0] hdr_data,
  output logic [31:0]  tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         tx_sop,
  output logic         tx_eop,
  output logic [1:0]   tx_empty,
  output logic [15:0]  tx_frames
);

  // state | meaning
  // IDLE  | waiting for a header, hdr_ready=1
  // CSUM  | summing the ten IPv4 halfwords, one per cycle
  // FOLD  | folding the carries and writing the checksum into the latched header
  // SEND  | streaming words 0..13, advancing on tx_valid&&tx_ready
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CSUM = 2'd1;
  localparam logic [1:0] ST_FOLD = 2'd2;
  localparam logic [1:0] ST_SEND = 2'd3;

  logic [1:0]   state_q, state_d;
  logic [431:0] hdr_q, hdr_d;
  logic [19:0]  acc_q, acc_d;
  logic [3:0]   i_q, i_d;
  logic [3:0]   widx_q, widx_d;
  logic [15:0]  frames_q, frames_d;
  logic [31:0]  tx_data_q, tx_data_d;
  logic         tx_valid_q, tx_valid_d;
  logic         tx_sop_q, tx_sop_d;
  logic         tx_eop_q, tx_eop_d;
  logic [1:0]   tx_empty_q, tx_empty_d;

  logic [15:0]  half [0:9];
  logic [31:0]  word [0:13];
  logic [447:0] hdr_pad;
  logic [15:0]  addend;
  logic [16:0]  s1;
  logic [16:0]  s2;

  always_comb begin
    for (int k = 0; k < 10; k++) begin
      half[k] = hdr_q[319 - 16*k -: 16];
    end
  end

  always_comb begin
    addend = (i_q == 4'd5) ? 16'h0000 : half[i_q];
    s1     = {1'b0, acc_q[15:0]} + {13'h0000, acc_q[19:16]};
    s2     = {1'b0, s1[15:0]} + {16'h0000, s1[16]};
  end

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    acc_d    = acc_q;
    i_d      = i_q;
    widx_d   = widx_q;
    frames_d = frames_q;
    case (state_q)
      ST_IDLE: begin
        if (hdr_valid) begin
          hdr_d   = hdr_data;
          acc_d   = '0;
          i_d     = '0;
          widx_d  = '0;
          state_d = CSUM_EN ? ST_CSUM : ST_SEND;
        end
      end
      ST_CSUM: begin
        acc_d = acc_q + {4'h0, addend};
        i_d   = i_q + 4'd1;
        if (i_q == 4'd9) begin
          state_d = ST_FOLD;
        end
      end
      ST_FOLD: begin
        hdr_d[239:224] = ~s2[15:0];
        widx_d         = '0;
        state_d        = ST_SEND;
      end
      default: begin
        if (tx_valid_q && tx_ready) begin
          if (widx_q == 4'd13) begin
            frames_d = frames_q + 16'd1;
            state_d  = ST_IDLE;
          end else begin
            widx_d = widx_q + 4'd1;
          end
        end
      end
    endcase
  end

  // Padding the header by two zero bytes makes word 13 a regular slice with [15:0]=0.
  always_comb begin
    hdr_pad = {hdr_d, 16'h0000};
    for (int k = 0; k < 14; k++) begin
      word[k] = hdr_pad[447 - 32*k -: 32];
    end
  end

  // Output registers load from next-state values so word 0 is valid on entering SEND
  // and everything holds while stalled.
  always_comb begin
    tx_valid_d = 1'b0;
    tx_data_d  = '0;
    tx_sop_d   = 1'b0;
    tx_eop_d   = 1'b0;
    tx_empty_d = '0;
    if (state_d == ST_SEND) begin
      tx_valid_d = 1'b1;
      tx_data_d  = word[widx_d];
      tx_sop_d   = (widx_d == 4'd0);
      tx_eop_d   = (widx_d == 4'd13);
      tx_empty_d = (widx_d == 4'd13) ? 2'd2 : 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      hdr_q      <= '0;
      acc_q      <= '0;
      i_q        <= '0;
      widx_q     <= '0;
      frames_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_sop_q   <= 1'b0;
      tx_eop_q   <= 1'b0;
      tx_empty_q <= '0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      acc_q      <= acc_d;
      i_q        <= i_d;
      widx_q     <= widx_d;
      frames_q   <= frames_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_sop_q   <= tx_sop_d;
      tx_eop_q   <= tx_eop_d;
      tx_empty_q <= tx_empty_d;
    end
  end

  assign hdr_ready = (state_q == ST_IDLE);
  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign tx_sop    = tx_sop_q;
  assign tx_eop    = tx_eop_q;
  assign tx_empty  = tx_empty_q;
  assign tx_frames = frames_q;

endmodule

// File: tb/tb_tx_header_serializer.sv
// Bench for tx_header_serializer: random headers checked against a byte-level reference
// (checksum by plain ones-complement arithmetic, words by byte slicing).
module tb_tx_header_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic         hv;
  logic [431:0] hd;
  logic         tx_ready;
  logic         sel;

  logic        hr1, tv1, sop1, eop1;
  logic [31:0] td1;
  logic [1:0]  te1;
  logic [15:0] tf1;
  logic        hr0, tv0, sop0, eop0;
  logic [31:0] td0;
  logic [1:0]  te0;
  logic [15:0] tf0;

  logic        o_hr, o_tv, o_sop, o_eop;
  logic [31:0] o_td;
  logic [1:0]  o_te;
  logic [15:0] o_tf;

  int nvec = 0;
  int nerr = 0;

  logic [7:0]  cur [54];
  logic [7:0]  saved [54];
  logic [31:0] cap [14];
  logic [15:0] exp_f1, exp_f0;
  logic [431:0] h_b;

  tx_header_serializer #(.CSUM_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .hdr_valid(hv && !sel), .hdr_ready(hr1), .hdr_data(hd),
    .tx_data(td1), .tx_valid(tv1), .tx_ready(tx_ready), .tx_sop(sop1), .tx_eop(eop1),
    .tx_empty(te1), .tx_frames(tf1)
  );

  tx_header_serializer #(.CSUM_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .hdr_valid(hv && sel), .hdr_ready(hr0), .hdr_data(hd),
    .tx_data(td0), .tx_valid(tv0), .tx_ready(tx_ready), .tx_sop(sop0), .tx_eop(eop0),
    .tx_empty(te0), .tx_frames(tf0)
  );

  assign o_hr  = sel ? hr0  : hr1;
  assign o_tv  = sel ? tv0  : tv1;
  assign o_sop = sel ? sop0 : sop1;
  assign o_eop = sel ? eop0 : eop1;
  assign o_td  = sel ? td0  : td1;
  assign o_te  = sel ? te0  : te1;
  assign o_tf  = sel ? tf0  : tf1;

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [431:0] pack_cur();
    logic [431:0] v;
    for (int n = 0; n < 54; n++) v[431 - 8*n -: 8] = cur[n];
    return v;
  endfunction

  function automatic logic [15:0] ref_csum();
    int unsigned s;
    s = 0;
    for (int k = 14; k < 34; k += 2) begin
      if (k != 24) s += {cur[k], cur[k+1]};
    end
    while (s > 32'h0000FFFF) s = (s & 32'h0000FFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  task automatic rand_cur();
    for (int n = 0; n < 54; n++) cur[n] = 8'($urandom);
  endtask

  task automatic run_frame(input bit stall, input int abort_w, input bit pre_next,
                           input logic [431:0] hnext, input bit csum);
    logic [7:0]  e [56];
    logic [15:0] c;
    logic [15:0] ef;
    int lat, w, cyc;
    bit hs;
    for (int n = 0; n < 54; n++) e[n] = cur[n];
    e[54] = 8'h00;
    e[55] = 8'h00;
    if (csum) begin
      c = ref_csum();
      e[24] = c[15:8];
      e[25] = c[7:0];
    end
    tx_ready = 1'b1;
    cyc = 0;
    while (!o_hr && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("hdr_ready_idle", {31'd0, o_hr}, 32'd1);
    hv = 1'b1;
    hd = pack_cur();
    @(negedge clk);
    if (pre_next) begin
      hd = hnext;
    end else begin
      hv = 1'b0;
      for (int k = 0; k < 14; k++) hd[32*k +: 16] = 16'($urandom);
    end
    chk("hdr_ready_busy", {31'd0, o_hr}, 32'd0);
    lat = 0;
    while (!o_tv && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, csum ? 32'd11 : 32'd0);
    w = 0;
    cyc = 0;
    while (w < 14 && cyc < 500) begin
      if (w == abort_w) begin
        ef = sel ? exp_f0 : exp_f1;
        reset = 1'b1;
        #1;
        chk("abort_tx_valid", {31'd0, o_tv}, 32'd0);
        chk("abort_hdr_ready", {31'd0, o_hr}, 32'd1);
        chk("abort_frames", {16'd0, o_tf}, {16'd0, ef});
        @(negedge clk);
        reset = 1'b0;
        hv = 1'b0;
        tx_ready = 1'b1;
        return;
      end
      chk("tx_valid", {31'd0, o_tv}, 32'd1);
      chk("tx_data", o_td, {e[4*w], e[4*w+1], e[4*w+2], e[4*w+3]});
      chk("tx_sop", {31'd0, o_sop}, (w == 0) ? 32'd1 : 32'd0);
      chk("tx_eop", {31'd0, o_eop}, (w == 13) ? 32'd1 : 32'd0);
      chk("tx_empty", {30'd0, o_te}, (w == 13) ? 32'd2 : 32'd0);
      tx_ready = (stall && $urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
      hs = tx_ready && o_tv;
      if (hs) cap[w] = o_td;
      @(negedge clk);
      if (hs) w++;
      cyc++;
    end
    chk("beats", w, 32'd14);
    tx_ready = 1'b1;
    if (sel) exp_f0 = exp_f0 + 16'd1;
    else     exp_f1 = exp_f1 + 16'd1;
    chk("post_tx_valid", {31'd0, o_tv}, 32'd0);
    chk("post_hdr_ready", {31'd0, o_hr}, 32'd1);
    chk("tx_frames", {16'd0, o_tf}, {16'd0, sel ? exp_f0 : exp_f1});
  endtask

  initial begin
    reset = 1'b1;
    hv = 1'b0;
    hd = '0;
    tx_ready = 1'b1;
    sel = 1'b0;
    exp_f1 = 16'd0;
    exp_f0 = 16'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx_valid", {31'd0, o_tv}, 32'd0);
    chk("rst_hdr_ready", {31'd0, o_hr}, 32'd1);
    chk("rst_tx_data", o_td, 32'd0);
    chk("rst_flags", {29'd0, o_sop, o_eop, o_te == 2'd0 ? 1'b0 : 1'b1}, 32'd0);
    chk("rst_frames", {16'd0, o_tf}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Abort at word 7, then a full frame must follow cleanly.
    rand_cur();
    run_frame(1'b0, 7, 1'b0, '0, 1'b1);

    // Known IPv4 header with checksum b861.
    rand_cur();
    {cur[14], cur[15], cur[16], cur[17], cur[18], cur[19], cur[20], cur[21], cur[22], cur[23]} =
      80'h4500_0073_0000_4000_4011;
    {cur[24], cur[25], cur[26], cur[27], cur[28], cur[29], cur[30], cur[31], cur[32], cur[33]} =
      80'h0000_c0a8_0001_c0a8_00c7;
    run_frame(1'b0, -1, 1'b0, '0, 1'b1);
    chk("t1_word6", cap[6], 32'hb861c0a8);

    // All-ones IP header: checksum folds to zero.
    for (int n = 0; n < 54; n++) cur[n] = 8'hFF;
    run_frame(1'b0, -1, 1'b0, '0, 1'b1);
    chk("t2_word6", cap[6], 32'h0000ffff);

    for (int f = 0; f < 4; f++) begin
      rand_cur();
      run_frame(1'b1, -1, 1'b0, '0, 1'b1);
    end

    // Counter wrap, then back-to-back headers.
    force dut1.frames_q = 16'hFFFF;
    @(negedge clk);
    release dut1.frames_q;
    exp_f1 = 16'hFFFF;
    rand_cur();
    for (int n = 0; n < 54; n++) saved[n] = cur[n];
    h_b = pack_cur();
    rand_cur();
    run_frame(1'b0, -1, 1'b1, h_b, 1'b1);
    for (int n = 0; n < 54; n++) cur[n] = saved[n];
    run_frame(1'b0, -1, 1'b0, '0, 1'b1);

    // Pass-through instance.
    sel = 1'b1;
    @(negedge clk);
    rand_cur();
    cur[24] = 8'h12;
    cur[25] = 8'h34;
    run_frame(1'b0, -1, 1'b0, '0, 1'b0);
    chk("t6_bytes24_25", {16'd0, cap[6][31:16]}, 32'h1234);
    rand_cur();
    run_frame(1'b1, -1, 1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
